// File: rtl/npc_pkg.sv
// Shared encodings for the NPC load/store path: access sizes and LSU FSM states.
package npc_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane helper: store data replication and mask, load extract/extend,
// and detection of misaligned or illegal-size accesses.
module lsu_lane_align
  import npc_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        wen_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] rd_sh;

  // Bring the addressed lane down to bit 0 so byte/half extraction is uniform.
  assign rd_sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    wdata_o = wdata_i;
    wmask_o = 4'b0000;
    rdata_o = rdata_i;
    err_o   = 1'b0;
    case (size_i)
      SZ_B: begin
        wdata_o = {4{wdata_i[7:0]}};
        wmask_o = 4'b0001 << off_i;
        rdata_o = {{24{~uns_i & rd_sh[7]}}, rd_sh[7:0]};
      end
      SZ_H: begin
        wdata_o = {2{wdata_i[15:0]}};
        wmask_o = 4'b0011 << off_i;
        rdata_o = {{16{~uns_i & rd_sh[15]}}, rd_sh[15:0]};
        err_o   = off_i[0];
      end
      SZ_W: begin
        wmask_o = 4'b1111;
        err_o   = |off_i;
      end
      default: err_o = 1'b1;
    endcase
    if (!wen_i) wmask_o = 4'b0000;
  end

endmodule

// File: rtl/lsu_mem_req.sv
// Load/store request sequencer: one core access at a time turned into a
// word-aligned memory transaction, with misalignment and timeout errors.
module lsu_mem_req
  import npc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output lsu_state_t  dbg_state_o
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  lsu_state_t  state_q, state_d;
  logic        wen_q, wen_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  logic        idle;
  logic [31:0] ln_wdata, ln_rdata;
  logic [3:0]  ln_wmask;
  logic        ln_err;

  assign idle = (state_q == IDLE);

  // One aligner serves both phases: live request fields while IDLE (store
  // shaping, error check), latched fields afterwards (load extraction).
  lsu_lane_align u_align (
    .off_i   (idle ? req_addr[1:0] : addr_q[1:0]),
    .size_i  (idle ? req_size      : size_q),
    .wen_i   (idle ? req_wen       : wen_q),
    .uns_i   (idle ? req_unsigned  : uns_q),
    .wdata_i (req_wdata),
    .rdata_i (mem_rdata),
    .wdata_o (ln_wdata),
    .wmask_o (ln_wmask),
    .rdata_o (ln_rdata),
    .err_o   (ln_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      wmask_q <= 4'b0000;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        wen_d   = req_wen;
        addr_d  = req_addr;
        size_d  = req_size;
        uns_d   = req_unsigned;
        wdata_d = ln_wdata;
        wmask_d = ln_wmask;
        err_d   = ln_err;
        rdata_d = 32'd0;
        state_d = ln_err ? RESP : REQ;
      end
      REQ: if (mem_req_ready) begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // Counter compares before incrementing, giving TIMEOUT+1 WAIT cycles.
        if (mem_resp_valid) begin
          rdata_d = wen_q ? 32'd0 : ln_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready     = idle;
  assign mem_req_valid = (state_q == REQ);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = resp_valid ? rdata_q : 32'd0;
  assign resp_err      = resp_valid & err_q;
  assign mem_wen       = wen_q;
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = {4'b0000, wmask_q};
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_mem_req.sv
// Directed bench for lsu_mem_req with TIMEOUT=4; checks sampled 1ns after each rising edge.
module tb_lsu_mem_req;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  lsu_state_t  dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  lsu_mem_req #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_rerr"}, 32'(resp_err), 32'd0);
    chk({tag, "_mvalid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_mwen"}, 32'(mem_wen), 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_mwdata"}, mem_wdata, 32'd0);
    chk({tag, "_mwmask"}, 32'(mem_wmask), 32'd0);
  endtask

  // Load with immediate ready/response; starts in IDLE, ends back in IDLE.
  task automatic fast_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rdata, input logic [31:0] exp);
    mem_req_ready = 1'b1;
    issue(1'b0, addr, 32'd0, size, uns);
    chk({tag, "_mvalid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_maddr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_mmask"}, 32'(mem_wmask), 32'd0);
    tick();
    mem_resp_valid = 1'b1; mem_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_rerr"}, 32'(resp_err), 32'd0);
    tick();
    chk({tag, "_ready_T4"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = SZ_B; req_unsigned = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = 32'd0;
    tick(); tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    fast_load("lb",  32'h8000_0003, SZ_B, 1'b0, 32'h80FF_1234, 32'hFFFF_FF80);
    fast_load("lbu", 32'h8000_0003, SZ_B, 1'b1, 32'h80FF_1234, 32'h0000_0080);
    fast_load("lh",  32'h8000_0000, SZ_H, 1'b0, 32'h1234_8001, 32'hFFFF_8001);
    fast_load("lhu", 32'h8000_0002, SZ_H, 1'b1, 32'hF234_8001, 32'h0000_F234);
    fast_load("lw",  32'h8000_0004, SZ_W, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // SH to upper half
    issue(1'b1, 32'h8000_0002, 32'h0000_ABCD, SZ_H, 1'b0);
    chk("sh_mvalid", 32'(mem_req_valid), 32'd1);
    chk("sh_maddr", mem_addr, 32'h8000_0000);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    chk("sh_wmask", 32'(mem_wmask), 32'h0000_000C);
    chk("sh_wen", 32'(mem_wen), 32'd1);
    tick();
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    chk("sh_rvalid", 32'(resp_valid), 32'd1);
    chk("sh_rdata", resp_rdata, 32'd0);
    chk("sh_rerr", 32'(resp_err), 32'd0);
    tick();

    // Misaligned LW: error at T+1, no memory request
    issue(1'b0, 32'h8000_0006, 32'd0, SZ_W, 1'b0);
    chk("lwmis_rvalid", 32'(resp_valid), 32'd1);
    chk("lwmis_rerr", 32'(resp_err), 32'd1);
    chk("lwmis_rdata", resp_rdata, 32'd0);
    chk("lwmis_mvalid", 32'(mem_req_valid), 32'd0);
    tick();
    chk("lwmis_mvalid2", 32'(mem_req_valid), 32'd0);
    chk("lwmis_ready", 32'(req_ready), 32'd1);

    // Misaligned half and illegal size
    issue(1'b0, 32'h8000_0001, 32'd0, SZ_H, 1'b0);
    chk("lhmis_rerr", 32'(resp_err), 32'd1);
    tick();
    issue(1'b0, 32'h8000_0000, 32'd0, 2'd3, 1'b0);
    chk("sz3_rerr", 32'(resp_err), 32'd1);
    chk("sz3_mvalid", 32'(mem_req_valid), 32'd0);
    tick();

    // SB with ready held low for 5 cycles
    mem_req_ready = 1'b0;
    issue(1'b1, 32'h8000_0101, 32'h0000_005A, SZ_B, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_mvalid", 32'(mem_req_valid), 32'd1);
      chk("stall_maddr", mem_addr, 32'h8000_0100);
      chk("stall_wdata", mem_wdata, 32'h5A5A_5A5A);
      chk("stall_wmask", 32'(mem_wmask), 32'h0000_0002);
      if (i < 4) tick();
    end
    mem_req_ready = 1'b1;
    tick();
    chk("stall_wait_mvalid", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("stall_rvalid", 32'(resp_valid), 32'd1);
    chk("stall_rerr", 32'(resp_err), 32'd0);
    tick();

    // Timeout: TIMEOUT=4 gives error pulse 5 cycles after entering WAIT
    issue(1'b0, 32'h8000_0010, 32'd0, SZ_W, 1'b0);
    tick();
    chk("to_state_wait", 32'(dbg_state), 32'(WAIT));
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("to_no_resp", 32'(resp_valid), 32'd0);
    end
    tick();
    chk("to_rvalid", 32'(resp_valid), 32'd1);
    chk("to_rerr", 32'(resp_err), 32'd1);
    chk("to_rdata", resp_rdata, 32'd0);
    tick();
    chk("to_ready", 32'(req_ready), 32'd1);
    chk("to_rvalid_off", 32'(resp_valid), 32'd0);

    // Reset while in WAIT, then a stray memory response
    issue(1'b1, 32'h8000_0020, 32'h1122_3344, SZ_W, 1'b0);
    tick();
    chk("rw_state_wait", 32'(dbg_state), 32'(WAIT));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_outputs("rw");
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_resp_valid = 1'b0;
    chk("stray_rvalid1", 32'(resp_valid), 32'd0);
    tick();
    chk("stray_rvalid2", 32'(resp_valid), 32'd0);
    chk("stray_ready", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_req.md
# lsu_mem_req

Load/store request sequencer sitting between the NPC execute stage and the data-memory port. It accepts one load or store at a time from the core and converts byte/half/word accesses into word-aligned memory transactions with a byte write mask. For loads it extracts and sign- or zero-extends the returned data. It flags misaligned accesses and memory timeouts as errors.

## Interface
- TIMEOUT, default 255: maximum number of cycles to wait for mem_resp_valid before returning an error (8-bit counter).
- clk  in  1  system clock; every register updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  zero-extend load data (LBU/LHU).
- resp_valid  out  1  one-cycle pulse carrying the result.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address, illegal size, or timeout.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_wen  out  1  write enable.
- mem_addr  out  32  equals {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  store data shifted into byte lane.
- mem_wmask  out  8  byte mask; [7:4] are always 0.
- mem_resp_valid  in  1  read data valid, or write done.
- mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE
  - req_ready=1.
  - If req_valid: latch wen, addr, wdata, size, and unsigned.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=3: go to RESP with err=1. No memory transaction is issued.
  - Otherwise go to REQ.
- REQ
  - mem_req_valid=1. Address, wdata, and mask are held stable until mem_req_ready.
  - Handshake completes in a cycle with mem_req_valid && mem_req_ready; then go to WAIT and clear the counter.
- WAIT
  - mem_req_valid=0.
  - On mem_resp_valid: capture mem_rdata and go to RESP with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to RESP with err=1.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Byte lane off = addr[1:0].
  - Byte: mask = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - Half: mask = 4'b0011<<off, wdata = {2{wdata[15:0]}}.
  - Word: mask = 4'b1111, wdata = wdata.
  - mem_wmask = 0 whenever wen=0.
- Load extraction: byte = rdata[8*off+:8], half = rdata[8*off+:16]. Sign-extend from bit 7/15 unless unsigned is set.
- Store response: resp_rdata = 0, resp_err = 0 on mem_resp_valid.
- mem_resp_valid seen outside WAIT is ignored.
- Reset (rst_n=0 at a clock edge, any state) forces IDLE. The in-flight transaction is abandoned; a late mem_resp_valid after reset is ignored.

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_rdata=0, resp_err=0, mem_req_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
- All outputs are registered or decoded from state only. There is no combinational path from req_* or mem_* inputs to any output.
- Best-case latency, request accepted at cycle T:
  - mem_req_valid at T+1.
  - With mem_req_ready at T+1 and mem_resp_valid at T+2, resp_valid at T+3.
  - Next request can be accepted at T+4.
- Error path: accept at T, resp_valid/resp_err at T+1.
- Timeout: resp_err asserts TIMEOUT+1 cycles after entering WAIT.

## Structure
- Shared package npc_pkg:
  - Size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2.
  - lsu_state_t enum {IDLE, REQ, WAIT, RESP}.
- One sub-module, lsu_lane_align (combinational):
  - Store shift/mask generation.
  - Load extract/extend.
  - Misalignment detect.
- The FSM and counter stay in lsu_mem_req.

## Test plan
- LB at 0x8000_0003, mem_rdata 0x80FF_1234, ready and resp immediate → mem_addr 0x8000_0000, resp_rdata 0xFFFF_FF80 at T+3. Same access with LBU → 0x0000_0080.
- SH at 0x8000_0002, wdata 0x0000_ABCD → mem_wdata 0xABCD_ABCD, mem_wmask 0x0C, mem_wen=1. Response has resp_err=0 and resp_rdata=0.
- LW at 0x8000_0006 → resp_err=1 at T+1. mem_req_valid never asserts.
- mem_req_ready held low 5 cycles → mem_req_valid and mem_addr/mem_wdata/mem_wmask stable for all 5 cycles. Completion follows normally after ready.
- TIMEOUT=4, mem_resp_valid never asserted → resp_err=1 pulse 5 cycles after entering WAIT, then req_ready=1.
- rst_n low for one cycle while in WAIT → IDLE next cycle with all outputs at reset values. A subsequent stray mem_resp_valid produces no resp_valid.
